i_cache: RTL and testbench
==========================

# i_cache

Direct-mapped, read-only instruction cache between the pipeline's IF-stage fetch port and the instruction memory. On a hit it returns the 16-bit instruction in the same cycle. On a miss it stalls the fetch port, fills a whole 4-word line from memory with a fixed latency, then serves the fetch. It also keeps hit and miss counters for performance reporting.

## Interface
- `MEM_LATENCY`, default 4: cycles from the start of a line read until `mem_data` is valid (≥1).
- `NUM_LINES`, default 4: number of cache lines. Power of two, ≥2. `IDX_BITS` = log2(`NUM_LINES`).
- `clk` input, 1: single clock. All state updates on posedge.
- `reset_n` input, 1: synchronous, active-low reset.
- `cpu_read` input, 1: fetch request from IF stage.
- `cpu_address` input, 16: word address of the fetch (PC).
- `cpu_data` output, 16: fetched instruction. Valid when `cpu_ready`=1.
- `cpu_ready` output, 1: hit this cycle. IF may latch `cpu_data`. 0 means stall.
- `mem_read` output, 1: line read request to instruction memory.
- `mem_address` output, 16: line base address (low 2 bits = 00).
- `mem_data` input, 64: line data. Word at offset k is in bits [16k+15:16k].
- `hit_count` output, 16: number of hit cycles.
- `miss_count` output, 16: number of misses.

## Operation
- Address split:
  - offset = addr[1:0]
  - index = addr[2+IDX_BITS-1:2]
  - tag = addr[15:2+IDX_BITS]
- Per-line storage: valid bit, tag, 4×16-bit words.
- hit = `cpu_read` & state==IDLE & valid[index] & tag match.
- `cpu_ready` = hit (combinational). `cpu_data` = word[offset] of the indexed line when hit, else 16'h0000.
- FSM has two states, IDLE and FILL.
  - IDLE, `cpu_read`=1, no hit: latch the line base of `cpu_address` into `miss_addr`, set cnt=1, go to FILL, increment `miss_count`.
  - IDLE, hit: increment `hit_count`. Stay in IDLE.
  - IDLE, `cpu_read`=0: no action.
  - FILL: `mem_read`=1, `mem_address`=`miss_addr`. If cnt==`MEM_LATENCY`: write `mem_data` into line index(`miss_addr`), set its tag and valid=1, go to IDLE. Otherwise cnt=cnt+1.
- `mem_read`=0 and `mem_address`=16'h0000 in IDLE.
- A fill uses only the latched `miss_addr`. Changes to `cpu_address` or `cpu_read` during FILL are ignored; the next lookup happens in the first IDLE cycle after the fill.
- A fill replaces the existing line at that index unconditionally. There is no write path: instruction memory is read-only.
- Counters are 16 bits and wrap from 16'hFFFF to 0. A cycle never increments both counters.

## Timing
- Reset (`reset_n`=0 at posedge) forces:
  - state=IDLE, cnt=0
  - all valid bits=0
  - `hit_count`=`miss_count`=0
  - `mem_read`=0, `cpu_ready`=0, `cpu_data`=0
- Reset during FILL aborts the fill. No line is written, and `mem_read`=0 from the cycle after the reset edge.
- Hit latency is 0: data is available in the request cycle.
- Miss with the miss detected in cycle T:
  - `cpu_ready`=0 in cycles T..T+`MEM_LATENCY`.
  - `mem_read`=1 in cycles T+1..T+`MEM_LATENCY`.
  - `mem_data` is sampled at the posedge ending cycle T+`MEM_LATENCY`.
  - `cpu_ready`=1 in cycle T+`MEM_LATENCY`+1.
- Memory contract: `mem_data` must be valid in the last FILL cycle while `mem_address` is held stable.
- Back-to-back misses to different lines are serialized. Each miss costs `MEM_LATENCY`+1 stall cycles.
- If the first IDLE cycle after a fill sees a different address that also misses, a new FILL starts with no extra cycle.

## Test plan
- Cold miss, default parameters:
  - Stimulus: reset, then `cpu_read`=1, `cpu_address`=16'h0000, memory line 0 = {16'h4003,16'h4002,16'h4001,16'h4000}.
  - Required: `cpu_ready`=0 for 5 cycles; cycle 6 `cpu_ready`=1, `cpu_data`=16'h4000; `miss_count`=1.
- Spatial hits:
  - Stimulus: after the cold miss, addresses 1, 2, 3 on consecutive cycles.
  - Required: `cpu_ready`=1 each cycle, data 16'h4001/4002/4003; `hit_count`=4; `mem_read` stays 0.
- Conflict eviction:
  - Stimulus: fetch 16'h0010 (same index, tag 1), then 16'h0000.
  - Required: both miss (`miss_count` +2), and each fill asserts `mem_address` of 16'h0010 and 16'h0000 respectively.
- Address change mid-fill:
  - Stimulus: miss on 16'h0004; in FILL cycle 2, change `cpu_address` to 16'h0008.
  - Required: the fill completes for 16'h0004 (`mem_address`=16'h0004 throughout); the next IDLE cycle misses on 16'h0008.
- Reset mid-fill:
  - Stimulus: assert `reset_n`=0 in FILL cycle 2, release, then fetch the same address.
  - Required: `mem_read` drops the cycle after the reset edge; the refetch misses (line not valid); counters restart from 0.
- `MEM_LATENCY`=1:
  - Stimulus: a miss on any address.
  - Required: `cpu_ready`=0 for exactly 2 cycles and `mem_read`=1 for exactly 1 cycle.

Source files
------------

// File: rtl/i_cache.sv
// Direct-mapped, read-only instruction cache between the IF-stage fetch port and instruction memory.
// Hits return data combinationally; misses stall while a whole 4-word line is filled.
module i_cache #(
   parameter int MEM_LATENCY = 4,
   parameter int NUM_LINES   = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_read,
   input  logic [15:0] cpu_address,
   output logic [15:0] cpu_data,
   output logic        cpu_ready,
   output logic        mem_read,
   output logic [15:0] mem_address,
   input  logic [63:0] mem_data,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   localparam int IDX_BITS = $clog2(NUM_LINES);
   localparam int TAG_BITS = 14 - IDX_BITS;
   localparam int CNT_W    = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] FILL = 1'b1;

   logic [0:0]          state;
   logic [CNT_W-1:0]    cnt;
   logic [15:0]         miss_addr;
   logic [NUM_LINES-1:0] valid;
   logic [TAG_BITS-1:0] tags  [NUM_LINES];
   logic [63:0]         lines [NUM_LINES];

   logic [1:0]          offset;
   logic [IDX_BITS-1:0] index;
   logic [TAG_BITS-1:0] tag;
   logic [IDX_BITS-1:0] fill_index;
   logic [TAG_BITS-1:0] fill_tag;
   logic                hit;
   logic                fill_done;

   assign offset     = cpu_address[1:0];
   assign index      = cpu_address[2+IDX_BITS-1:2];
   assign tag        = cpu_address[15:2+IDX_BITS];
   assign fill_index = miss_addr[2+IDX_BITS-1:2];
   assign fill_tag   = miss_addr[15:2+IDX_BITS];

   assign hit       = cpu_read && (state == IDLE) && valid[index] && (tags[index] == tag);
   assign fill_done = (state == FILL) && (cnt == LAST_CNT);

   assign cpu_ready   = hit;
   assign cpu_data    = hit ? lines[index][{offset, 4'b0000} +: 16] : 16'h0000;
   assign mem_read    = (state == FILL);
   assign mem_address = mem_read ? miss_addr : 16'h0000;

   // Control state; a reset edge during FILL simply drops back to IDLE without writing the line.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         miss_addr  <= 16'h0000;
         valid      <= '0;
         hit_count  <= 16'h0000;
         miss_count <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  hit_count <= hit_count + 16'd1;
               end else if (cpu_read) begin
                  miss_addr  <= {cpu_address[15:2], 2'b00};
                  cnt        <= CNT_W'(1);
                  state      <= FILL;
                  miss_count <= miss_count + 16'd1;
               end
            end
            FILL: begin
               if (cnt == LAST_CNT) begin
                  valid[fill_index] <= 1'b1;
                  cnt               <= '0;
                  state             <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag and data arrays need no reset: the valid bits gate every use.
   always_ff @(posedge clk) begin
      if (reset_n && fill_done) begin
         tags[fill_index]  <= fill_tag;
         lines[fill_index] <= mem_data;
      end
   end

endmodule

// File: tb/tb_i_cache.sv
// Self-checking bench for i_cache: directed fetch sequences with a scoreboard of expected
// instruction words and a small reference model of the cache contents.
module tb_i_cache;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_read;
   logic [15:0] cpu_address;
   logic [15:0] cpu_data;
   logic        cpu_ready;
   logic        mem_read;
   logic [15:0] mem_address;
   logic [63:0] mem_data;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   logic        l1_read;
   logic [15:0] l1_address;
   logic [15:0] l1_data;
   logic        l1_ready;
   logic        l1_mem_read;
   logic [15:0] l1_mem_address;
   logic [63:0] l1_mem_data;
   logic [15:0] l1_hits;
   logic [15:0] l1_misses;

   logic [15:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_hits;
   int          exp_misses;
   logic        m_valid [4];
   logic [11:0] m_tag   [4];

   always #5 clk = ~clk;

   // Instruction memory: word at address a holds 16'h4000 + a.
   function automatic logic [63:0] line_of(input logic [15:0] b);
      return {16'h4003 + b, 16'h4002 + b, 16'h4001 + b, 16'h4000 + b};
   endfunction

   assign mem_data    = line_of(mem_address);
   assign l1_mem_data = line_of(l1_mem_address);

   i_cache dut (
      .clk(clk), .reset_n(reset_n), .cpu_read(cpu_read), .cpu_address(cpu_address),
      .cpu_data(cpu_data), .cpu_ready(cpu_ready), .mem_read(mem_read),
      .mem_address(mem_address), .mem_data(mem_data),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   i_cache #(.MEM_LATENCY(1), .NUM_LINES(4)) dut_l1 (
      .clk(clk), .reset_n(reset_n), .cpu_read(l1_read), .cpu_address(l1_address),
      .cpu_data(l1_data), .cpu_ready(l1_ready), .mem_read(l1_mem_read),
      .mem_address(l1_mem_address), .mem_data(l1_mem_data),
      .hit_count(l1_hits), .miss_count(l1_misses)
   );

   task automatic check(input int obs, input int exp, input string tag);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int predict(input logic [15:0] a);
      return (m_valid[a[3:2]] && (m_tag[a[3:2]] == a[15:4])) ? 0 : 5;
   endfunction

   task automatic model_fill(input logic [15:0] a);
      m_valid[a[3:2]] = 1'b1;
      m_tag[a[3:2]]   = a[15:4];
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 12'h000;
      end
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   // Called just after a posedge; returns just after the posedge that ends the serving cycle.
   task automatic fetch(input logic [15:0] addr, input int exp_stall, input string tag);
      int          stalls;
      int          mreads;
      int          badaddr;
      logic [15:0] base;
      base    = {addr[15:2], 2'b00};
      stalls  = 0;
      mreads  = 0;
      badaddr = 0;
      exp_q.push_back(16'h4000 + addr);
      cpu_read    = 1'b1;
      cpu_address = addr;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (mem_read) begin
            mreads++;
            if (mem_address !== base) badaddr++;
         end
         if (cpu_ready) break;
         stalls++;
         @(posedge clk);
         #1;
      end
      check(int'(cpu_ready), 1, {tag, " ready"});
      check(stalls, exp_stall, {tag, " stall cycles"});
      check(mreads, (exp_stall > 0) ? exp_stall - 1 : 0, {tag, " mem_read cycles"});
      check(badaddr, 0, {tag, " mem_address"});
      check(int'(cpu_data), int'(exp_q.pop_front()), {tag, " data"});
      if (exp_stall > 0) exp_misses++;
      exp_hits++;
      model_fill(addr);
      @(posedge clk);
      #1;
      cpu_read = 1'b0;
   endtask

   task automatic check_counters(input string tag);
      check(int'(hit_count), exp_hits, {tag, " hit_count"});
      check(int'(miss_count), exp_misses, {tag, " miss_count"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          stalls;
      int          mreads;
      int          badaddr;
      logic [15:0] a;
      logic [15:0] want;

      reset_n     = 1'b0;
      cpu_read    = 1'b0;
      cpu_address = 16'h0000;
      l1_read     = 1'b0;
      l1_address  = 16'h0000;
      model_reset();

      repeat (2) @(posedge clk);
      @(negedge clk);
      check(int'(cpu_ready), 0, "reset cpu_ready");
      check(int'(cpu_data), 0, "reset cpu_data");
      check(int'(mem_read), 0, "reset mem_read");
      check(int'(mem_address), 0, "reset mem_address");
      check_counters("reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // MEM_LATENCY=1 instance: two not-ready cycles, one mem_read cycle.
      l1_read    = 1'b1;
      l1_address = 16'h0020;
      exp_q.push_back(16'h4020);
      stalls = 0;
      mreads = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (l1_mem_read) mreads++;
         if (l1_ready) break;
         stalls++;
         @(posedge clk);
         #1;
      end
      check(int'(l1_ready), 1, "lat1 ready");
      check(stalls, 2, "lat1 stall cycles");
      check(mreads, 1, "lat1 mem_read cycles");
      check(int'(l1_data), int'(exp_q.pop_front()), "lat1 data");
      @(posedge clk);
      #1;
      l1_read = 1'b0;
      @(negedge clk);
      check(int'(l1_misses), 1, "lat1 miss_count");
      check(int'(l1_hits), 1, "lat1 hit_count");
      @(posedge clk);
      #1;

      // Cold miss, then spatial hits within the same line.
      fetch(16'h0000, 5, "cold miss");
      check_counters("cold miss");
      fetch(16'h0001, 0, "hit 1");
      fetch(16'h0002, 0, "hit 2");
      fetch(16'h0003, 0, "hit 3");
      check_counters("spatial");

      // Conflict eviction at index 0.
      fetch(16'h0010, 5, "conflict 0010");
      fetch(16'h0000, 5, "conflict 0000");
      check_counters("conflict");

      // Address change during fill: 0004 completes, then 0008 misses immediately.
      exp_q.push_back(16'h4008);
      cpu_read    = 1'b1;
      cpu_address = 16'h0004;
      stalls  = 0;
      mreads  = 0;
      badaddr = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (mem_read) begin
            mreads++;
            want = (c <= 4) ? 16'h0004 : 16'h0008;
            if (mem_address !== want) badaddr++;
         end
         if (cpu_ready) break;
         stalls++;
         @(posedge clk);
         #1;
         if (c == 1) cpu_address = 16'h0008;
      end
      check(stalls, 10, "midfill stall cycles");
      check(mreads, 8, "midfill mem_read cycles");
      check(badaddr, 0, "midfill mem_address");
      check(int'(cpu_data), int'(exp_q.pop_front()), "midfill data");
      exp_misses += 2;
      exp_hits++;
      model_fill(16'h0004);
      model_fill(16'h0008);
      @(posedge clk);
      #1;
      cpu_read = 1'b0;
      check_counters("midfill");
      fetch(16'h0004, 0, "midfill line kept");

      // Random fetches over the first 32 words, predicted by the cache model.
      for (int i = 0; i < 20; i++) begin
         a = 16'($urandom_range(0, 31));
         fetch(a, predict(a), "random");
      end
      check_counters("random");

      // Reset during FILL cycle 2 aborts the fill.
      cpu_read    = 1'b1;
      cpu_address = 16'h100C;
      @(negedge clk);
      check(int'(mem_read), 0, "rstfill miss cycle mem_read");
      @(posedge clk);
      #1;
      cpu_read = 1'b0;
      @(negedge clk);
      check(int'(mem_read), 1, "rstfill fill1 mem_read");
      check(int'(mem_address), 16'h100C, "rstfill fill1 mem_address");
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check(int'(mem_read), 0, "rstfill mem_read after reset");
      check(int'(mem_address), 0, "rstfill mem_address after reset");
      model_reset();
      check_counters("rstfill after reset");
      @(posedge clk);
      #1;
      fetch(16'h100C, 5, "rstfill refetch");
      fetch(16'h0000, 5, "rstfill line0 invalid");
      check_counters("rstfill end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
